ripple_count_monitor: RTL and testbench
=======================================

Name: ripple_count_monitor

Overview:
- Sits directly downstream of the 3-bit ripple down counter.
- Takes the counter's asynchronous, glitch-prone count bits into the system clock domain and accepts a value only after it has held stable.
- Checks that every accepted value is exactly one below the previous value (modulo 2^WIDTH).
- Extends the count with a wrap counter and reports update, wrap and skip events as single-cycle pulses.

Parameters:
- WIDTH, 3, width of the ripple counter input.
- STABLE_CYCLES, 2, consecutive identical synchronized samples required before a value is accepted (legal range 1..15).
- EXT_WIDTH, 8, width of the wrap counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cnt_in  input  WIDTH  raw ripple counter outputs, asynchronous to clk.
- clr  input  1  synchronous clear back to the unlocked state.
- cnt_val  output  WIDTH  last accepted count.
- cnt_upd  output  1  one-cycle pulse when cnt_val changes.
- wrap_pulse  output  1  one-cycle pulse on a legal 0 -> 2^WIDTH-1 step.
- wrap_count  output  EXT_WIDTH  number of legal wraps, modulo 2^EXT_WIDTH.
- skip_pulse  output  1  one-cycle pulse on an illegal step.
- step_err  output  1  sticky flag, set by any illegal step.
- locked  output  1  high once a first value has been accepted.

Behaviour:
- Reset: rst_n low asynchronously clears every flop, including the synchronizer, sample history, state and all outputs. Reset values: cnt_val=0, cnt_upd=0, wrap_pulse=0, wrap_count=0, skip_pulse=0, step_err=0, locked=0, state=UNLOCKED.
- Synchronizer: two flops per bit (s1, s2), no logic between them.
- Stability filter:
  - s2 feeds a history of STABLE_CYCLES-1 delayed copies.
  - A candidate is stable when s2 and all history entries are equal.
  - For STABLE_CYCLES=1, s2 alone is the candidate.
- Accept event: candidate is stable AND (state==UNLOCKED OR candidate != cnt_val). All outputs are registered on the edge following the accept condition.
- Latency: with cnt_in settled before rising edge 1, outputs update at edge STABLE_CYCLES+2 (edge 4 at default). Any change of cnt_in during filtering restarts the stability count.
- States: UNLOCKED, LOCKED.
  - UNLOCKED + accept:
    - cnt_val <= candidate, locked <= 1, cnt_upd pulses.
    - No step check; no wrap or skip pulse.
    - Go to LOCKED.
  - LOCKED + accept with candidate == (cnt_val-1) mod 2^WIDTH:
    - cnt_val <= candidate, cnt_upd pulses.
    - If cnt_val==0 (candidate == 2^WIDTH-1): wrap_pulse pulses and wrap_count increments, rolling over from all-ones to 0.
  - LOCKED + accept with any other candidate:
    - cnt_val <= candidate (resync), cnt_upd pulses, skip_pulse pulses, step_err <= 1.
    - wrap_count unchanged, even if the candidate is 2^WIDTH-1.
  - A candidate stable and equal to cnt_val while LOCKED produces no pulse.
- clr (highest priority below reset), taking effect at the next edge:
  - state <= UNLOCKED.
  - locked, step_err, wrap_count, pulses <= 0.
  - Stability history cleared to force a fresh filter.
  - cnt_val holds its value.
  - Synchronizer flops are not cleared.
  - An accept coinciding with clr is discarded.
- Pulses last exactly one cycle. At most one accept occurs per cycle. cnt_upd is asserted together with every wrap_pulse and every skip_pulse.
- Reset mid-operation: immediate clear. After release, behaviour is identical to power-up, and the first accepted value does not raise skip.

Test Plan:
- Reset release, cnt_in=5 held -> at edge 4: cnt_val=5, locked=1, cnt_upd one cycle, skip_pulse=0, step_err=0.
- Locked at 5, drive 4,3,2,1,0,7 with each value held 6 clocks -> six cnt_upd pulses; one wrap_pulse on 0->7; wrap_count=1; step_err=0.
- Locked at 3, drive 1 -> cnt_val=1, skip_pulse one cycle, step_err=1 and stays 1 through later legal steps; wrap_count unchanged.
- Locked at 6, glitch cnt_in to 2 for 1 clock and then back to 6 (STABLE_CYCLES=2) -> no cnt_upd, no skip_pulse; cnt_val stays 6.
- Wrap counter rollover: drive 256 full down-cycles with EXT_WIDTH=8 -> wrap_count returns to 0 after the 256th wrap_pulse.
- Assert clr while step_err=1 and wrap_count=3, then present 4 -> locked=0, step_err=0, wrap_count=0 after clr; next accept relocks at 4 with no skip_pulse. Also assert rst_n low mid-sequence -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// Synchronizes and debounces a ripple down-counter, verifies each accepted value
// steps down by one, and extends the count with a wrap counter.
module ripple_count_monitor #(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned EXT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic                 clr,
  output logic [WIDTH-1:0]     cnt_val,
  output logic                 cnt_upd,
  output logic                 wrap_pulse,
  output logic [EXT_WIDTH-1:0] wrap_count,
  output logic                 skip_pulse,
  output logic                 step_err,
  output logic                 locked
);

  localparam int unsigned HIST_N = (STABLE_CYCLES > 1) ? STABLE_CYCLES - 1 : 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     s1_q, s2_q;
  logic [1:0]           sync_vld_q;
  logic [WIDTH-1:0]     hist_q [HIST_N];
  logic [HIST_N-1:0]    hist_vld_q;
  logic [WIDTH-1:0]     cnt_val_q;
  logic                 cnt_upd_q, wrap_pulse_q, skip_pulse_q, step_err_q, locked_q;
  logic [EXT_WIDTH-1:0] wrap_count_q;

  logic                 stable;
  logic                 accept;
  logic [WIDTH-1:0]     dec_val;

  // Two-flop synchronizer; valid bits keep reset contents out of the filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      sync_vld_q <= '0;
    end else begin
      s1_q       <= cnt_in;
      s2_q       <= s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  // Sample history behind s2; clr empties it so a fresh filter must complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(HIST_N); i++) hist_q[i] <= '0;
      hist_vld_q <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(HIST_N); i++) hist_q[i] <= '0;
      hist_vld_q <= '0;
    end else begin
      hist_q[0]     <= s2_q;
      hist_vld_q[0] <= sync_vld_q[1];
      for (int i = 1; i < int'(HIST_N); i++) begin
        hist_q[i]     <= hist_q[i-1];
        hist_vld_q[i] <= hist_vld_q[i-1];
      end
    end
  end

  always_comb begin
    stable = sync_vld_q[1];
    for (int i = 0; i < int'(STABLE_CYCLES) - 1; i++) begin
      if (!hist_vld_q[i] || (hist_q[i] != s2_q)) stable = 1'b0;
    end
  end

  assign accept  = stable && ((state_q == UNLOCKED) || (s2_q != cnt_val_q));
  assign dec_val = cnt_val_q - WIDTH'(1);

  // Lock/step-check state machine with registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      cnt_val_q    <= '0;
      cnt_upd_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
      skip_pulse_q <= 1'b0;
      step_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      cnt_upd_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
      skip_pulse_q <= 1'b0;
      if (clr) begin
        state_q      <= UNLOCKED;
        locked_q     <= 1'b0;
        step_err_q   <= 1'b0;
        wrap_count_q <= '0;
      end else if (accept) begin
        cnt_val_q <= s2_q;
        cnt_upd_q <= 1'b1;
        if (state_q == UNLOCKED) begin
          state_q  <= LOCKED;
          locked_q <= 1'b1;
        end else if (s2_q == dec_val) begin
          if (cnt_val_q == '0) begin
            wrap_pulse_q <= 1'b1;
            wrap_count_q <= wrap_count_q + EXT_WIDTH'(1);
          end
        end else begin
          skip_pulse_q <= 1'b1;
          step_err_q   <= 1'b1;
        end
      end
    end
  end

  assign cnt_val    = cnt_val_q;
  assign cnt_upd    = cnt_upd_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;
  assign skip_pulse = skip_pulse_q;
  assign step_err   = step_err_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Scoreboard bench for ripple_count_monitor: expected update events are queued
// as values are driven and popped whenever the DUT pulses cnt_upd.
module tb_ripple_count_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cnt_in;
  logic       clr;
  logic [2:0] cnt_val;
  logic       cnt_upd, wrap_pulse, skip_pulse, step_err, locked;
  logic [7:0] wrap_count;

  ripple_count_monitor #(.WIDTH(3), .STABLE_CYCLES(2), .EXT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .clr(clr),
    .cnt_val(cnt_val), .cnt_upd(cnt_upd), .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count), .skip_pulse(skip_pulse), .step_err(step_err),
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] val;
    logic       wrap;
    logic       skip;
    logic [7:0] wc;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_upd = 0, n_wrap = 0, n_skip = 0;

  logic       m_locked = 1'b0;
  logic [2:0] m_val    = '0;
  logic [7:0] m_wc     = '0;
  logic       m_err    = 1'b0;

  task automatic predict(input logic [2:0] v);
    exp_t       e;
    logic [2:0] dec;
    dec    = m_val - 3'd1;
    e.val  = v;
    e.wrap = 1'b0;
    e.skip = 1'b0;
    if (!m_locked) begin
      m_locked = 1'b1;
      m_val    = v;
      e.wc = m_wc; e.err = m_err;
      exp_q.push_back(e);
    end else if (v != m_val) begin
      if (v == dec) begin
        if (m_val == 3'd0) begin
          e.wrap = 1'b1;
          m_wc   = m_wc + 8'd1;
        end
      end else begin
        e.skip = 1'b1;
        m_err  = 1'b1;
      end
      m_val = v;
      e.wc = m_wc; e.err = m_err;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_clear();
    m_locked = 1'b0;
    m_wc     = '0;
    m_err    = 1'b0;
  endtask

  task automatic drive(input logic [2:0] v, input int hold);
    @(posedge clk); #1;
    cnt_in = v;
    predict(v);
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; cnt_in = 3'd5;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cnt_val, cnt_upd, wrap_pulse, wrap_count, skip_pulse, step_err, locked} !== 15'd0) begin
      bad++;
      $display("FAIL reset_values: got val=%0d upd=%b wrap=%b wc=%0d skip=%b err=%b lock=%b, want all 0",
               cnt_val, cnt_upd, wrap_pulse, wrap_count, skip_pulse, step_err, locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    predict(3'd5);
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (n == 3) begin
        total++;
        if ({cnt_upd, locked} !== 2'b00) begin
          bad++;
          $display("FAIL latency_early: edge3 upd=%b lock=%b, want 0 0", cnt_upd, locked);
        end
      end
      if (n == 4) begin
        total++;
        if ({cnt_upd, locked, cnt_val, skip_pulse, step_err} !== {1'b1, 1'b1, 3'd5, 1'b0, 1'b0}) begin
          bad++;
          $display("FAIL first_lock: edge4 upd=%b lock=%b val=%0d skip=%b err=%b, want 1 1 5 0 0",
                   cnt_upd, locked, cnt_val, skip_pulse, step_err);
        end
      end
      if (n == 5) begin
        total++;
        if (cnt_upd !== 1'b0) begin
          bad++;
          $display("FAIL upd_width: edge5 upd=%b, want 0", cnt_upd);
        end
      end
    end
  endtask

  task automatic test_down_seq();
    int u0, w0;
    logic [2:0] seq [6];
    seq = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    u0 = n_upd; w0 = n_wrap;
    foreach (seq[i]) drive(seq[i], 6);
    total++;
    if ({32'(n_upd - u0), 32'(n_wrap - w0), wrap_count, step_err} !== {32'd6, 32'd1, 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL down_seq: upd=%0d wraps=%0d wc=%0d err=%b, want 6 1 1 0",
               n_upd - u0, n_wrap - w0, wrap_count, step_err);
    end
  endtask

  task automatic test_skip();
    int s0;
    logic [2:0] seq [4];
    seq = '{3'd6, 3'd5, 3'd4, 3'd3};
    foreach (seq[i]) drive(seq[i], 6);
    s0 = n_skip;
    drive(3'd1, 6);
    total++;
    if ({cnt_val, step_err, wrap_count, 32'(n_skip - s0)} !== {3'd1, 1'b1, 8'd1, 32'd1}) begin
      bad++;
      $display("FAIL skip_step: val=%0d err=%b wc=%0d skips=%0d, want 1 1 1 1",
               cnt_val, step_err, wrap_count, n_skip - s0);
    end
    drive(3'd0, 6);
    drive(3'd7, 6);
    total++;
    if ({step_err, wrap_count} !== {1'b1, 8'd2}) begin
      bad++;
      $display("FAIL err_sticky: err=%b wc=%0d, want 1 2", step_err, wrap_count);
    end
  endtask

  task automatic test_glitch();
    int u0, s0;
    drive(3'd6, 6);
    u0 = n_upd; s0 = n_skip;
    @(posedge clk); #1; cnt_in = 3'd2;
    @(posedge clk); #1; cnt_in = 3'd6;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if ({cnt_val, 32'(n_upd - u0), 32'(n_skip - s0)} !== {3'd6, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL glitch: val=%0d upd=%0d skips=%0d, want 6 0 0", cnt_val, n_upd - u0, n_skip - s0);
    end
  endtask

  task automatic test_clr();
    logic [2:0] seq [7];
    int s0;
    seq = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    foreach (seq[i]) drive(seq[i], 6);
    total++;
    if ({step_err, wrap_count} !== {1'b1, 8'd3}) begin
      bad++;
      $display("FAIL pre_clr: err=%b wc=%0d, want 1 3", step_err, wrap_count);
    end
    s0 = n_skip;
    @(posedge clk); #1;
    clr = 1'b1; cnt_in = 3'd4;
    model_clear();
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if ({locked, step_err, wrap_count, cnt_val} !== {1'b0, 1'b0, 8'd0, 3'd7}) begin
      bad++;
      $display("FAIL clr_state: lock=%b err=%b wc=%0d val=%0d, want 0 0 0 7",
               locked, step_err, wrap_count, cnt_val);
    end
    predict(3'd4);
    repeat (6) @(posedge clk);
    #1;
    total++;
    if ({locked, cnt_val, 32'(n_skip - s0)} !== {1'b1, 3'd4, 32'd0}) begin
      bad++;
      $display("FAIL clr_relock: lock=%b val=%0d skips=%0d, want 1 4 0", locked, cnt_val, n_skip - s0);
    end
  endtask

  task automatic test_wrap_rollover();
    int w0;
    w0 = n_wrap;
    for (int v = 3; v >= 0; v--) drive(3'(v), 5);
    for (int c = 0; c < 256; c++) begin
      for (int v = 7; v >= 0; v--) drive(3'(v), 5);
    end
    total++;
    if ({wrap_count, 32'(n_wrap - w0), step_err} !== {8'd0, 32'd256, 1'b0}) begin
      bad++;
      $display("FAIL rollover: wc=%0d wraps=%0d err=%b, want 0 256 0", wrap_count, n_wrap - w0, step_err);
    end
  endtask

  task automatic test_async_reset();
    int s0;
    drive(3'd7, 6);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({cnt_val, cnt_upd, wrap_pulse, wrap_count, skip_pulse, step_err, locked} !== 15'd0) begin
      bad++;
      $display("FAIL async_reset: got val=%0d upd=%b wrap=%b wc=%0d skip=%b err=%b lock=%b, want all 0",
               cnt_val, cnt_upd, wrap_pulse, wrap_count, skip_pulse, step_err, locked);
    end
    model_clear();
    exp_q.delete();
    cnt_in = 3'd2;
    s0 = n_skip;
    @(negedge clk);
    rst_n = 1'b1;
    predict(3'd2);
    repeat (6) @(posedge clk);
    #1;
    total++;
    if ({locked, cnt_val, wrap_count, step_err, 32'(n_skip - s0)} !== {1'b1, 3'd2, 8'd0, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_relock: lock=%b val=%0d wc=%0d err=%b skips=%0d, want 1 2 0 0 0",
               locked, cnt_val, wrap_count, step_err, n_skip - s0);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected updates never seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; cnt_in = 3'd5;
    fork
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
          total++;
          if (((wrap_pulse | skip_pulse) & ~cnt_upd) !== 1'b0) begin
            bad++;
            $display("FAIL pulse_pair: wrap=%b skip=%b without upd=%b", wrap_pulse, skip_pulse, cnt_upd);
          end
          if (cnt_upd === 1'b1) begin
            n_upd++;
            if (wrap_pulse === 1'b1) n_wrap++;
            if (skip_pulse === 1'b1) n_skip++;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_upd: val=%0d wrap=%b skip=%b, want no update",
                       cnt_val, wrap_pulse, skip_pulse);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              if ({cnt_val, wrap_pulse, skip_pulse, wrap_count, step_err, locked} !==
                  {e.val, e.wrap, e.skip, e.wc, e.err, 1'b1}) begin
                bad++;
                $display("FAIL update_event: got val=%0d wrap=%b skip=%b wc=%0d err=%b lock=%b, want %0d %b %b %0d %b 1",
                         cnt_val, wrap_pulse, skip_pulse, wrap_count, step_err, locked,
                         e.val, e.wrap, e.skip, e.wc, e.err);
              end
            end
          end
        end
      end
    join_none

    test_reset();         check_drained("reset");
    test_down_seq();      check_drained("down_seq");
    test_skip();          check_drained("skip");
    test_glitch();        check_drained("glitch");
    test_clr();           check_drained("clr");
    test_wrap_rollover(); check_drained("rollover");
    test_async_reset();   check_drained("async_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
